// File: rtl/mux_arbiter16_pkg.sv
// Shared definitions for the two-source round-robin mux arbiter:
// FSM state encoding, source codes and the grant decision helpers.
package mux_arbiter16_pkg;

  // Output register occupancy: IDLE = empty, HOLD = holding a word.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_t;

  // Source identifiers; the value doubles as the mux select.
  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

  // A lone valid source always wins; on a tie the priority pointer decides.
  // With no valid source the result is unused, so prio is returned.
  function automatic src_t pick_grant(input logic a_valid,
                                      input logic b_valid,
                                      input src_t prio);
    src_t win;
    win = prio;
    if (a_valid && !b_valid) begin
      win = SRC_A;
    end else if (b_valid && !a_valid) begin
      win = SRC_B;
    end
    return win;
  endfunction

  // The pointer moves to whichever source did not just win.
  function automatic src_t other_src(input src_t s);
    return (s == SRC_A) ? SRC_B : SRC_A;
  endfunction

endpackage

// File: rtl/mux_arbiter16_mux.sv
// Plain 2:1 word multiplexer shared by the arbiter datapath.
// sel = 0 passes a, sel = 1 passes b.
module mux #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  // Select one of the two input words.
  always_comb begin
    y = a;
    if (sel) begin
      y = b;
    end
  end

endmodule

// File: rtl/mux_arbiter16.sv
// Round-robin arbiter sharing one 2:1 word mux between sources A and B.
// The chosen word is registered and offered on a single valid/ready
// output channel; saturating per-source grant counters aid debug.
// Note: a_ready/b_ready depend combinationally on y_ready (a full output
// register can be refilled in the same cycle the consumer drains it).
// y_valid, y_data and y_src are pure register outputs.
module mux_arbiter16
  import mux_arbiter16_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  output logic             y_src,
  input  logic             y_ready,
  output logic             sel,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  arb_state_t       state;
  arb_state_t       state_nxt;
  src_t             prio;
  src_t             grant;
  logic             sel_q;
  logic             any_valid;
  logic             load;
  logic             xfer;
  logic [WIDTH-1:0] mux_y;

  // Grant decision, mux select and the ready handshake for both sources.
  always_comb begin
    any_valid = a_valid | b_valid;
    grant     = pick_grant(a_valid, b_valid, prio);
    sel       = sel_q;
    if (any_valid) begin
      sel = (grant == SRC_B);
    end
    load    = (state == ARB_IDLE) | y_ready;
    a_ready = load & a_valid & (grant == SRC_A);
    b_ready = load & b_valid & (grant == SRC_B);
    xfer    = a_ready | b_ready;
  end

  mux #(
    .WIDTH(WIDTH)
  ) u_mux (
    .a  (a_data),
    .b  (b_data),
    .sel(sel),
    .y  (mux_y)
  );

  // Next-state logic: any transfer fills the register, a drain empties it.
  always_comb begin
    state_nxt = state;
    if (xfer) begin
      state_nxt = ARB_HOLD;
    end else if ((state == ARB_HOLD) && y_ready) begin
      state_nxt = ARB_IDLE;
    end
  end

  // State register; reset discards any held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign y_valid = (state == ARB_HOLD);

  // Priority pointer and remembered select, both advanced by grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio  <= SRC_A;
      sel_q <= 1'b0;
    end else begin
      if (any_valid) begin
        sel_q <= (grant == SRC_B);
      end
      if (xfer) begin
        prio <= other_src(grant);
      end
    end
  end

  // Output word register: captures the mux output and its source on a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_data <= '0;
      y_src  <= 1'b0;
    end else if (xfer) begin
      y_data <= mux_y;
      y_src  <= (grant == SRC_B);
    end
  end

  // Saturating grant counters, updated on the same edge as the transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (a_ready && (cnt_a != CNT_MAX)) begin
        cnt_a <= cnt_a + CNT_ONE;
      end
      if (b_ready && (cnt_b != CNT_MAX)) begin
        cnt_b <= cnt_b + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_mux_arbiter16.sv
// Self-checking bench for mux_arbiter16: directed scenarios plus random
// traffic, compared against a behavioural model through a word scoreboard.
module tb_mux_arbiter16;

  localparam int WIDTH = 16;

  typedef struct packed {
    logic        src;
    logic [15:0] data;
  } word_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             a_valid = 1'b0;
  logic [WIDTH-1:0] a_data = '0;
  logic             b_valid = 1'b0;
  logic [WIDTH-1:0] b_data = '0;
  logic             y_ready = 1'b0;
  logic             a_ready, b_ready, y_valid, y_src, sel;
  logic [WIDTH-1:0] y_data;
  logic [7:0]       cnt_a, cnt_b;

  logic             a_ready2, b_ready2, y_valid2, y_src2, sel2;
  logic [WIDTH-1:0] y_data2;
  logic [1:0]       cnt2_a, cnt2_b;

  int    total = 0;
  int    bad = 0;
  word_t exp_q[$];

  // Behavioural model: register occupancy, pointer, last select, counts.
  bit full_m, prio_m, sel_m;
  int cnt_am, cnt_bm;
  bit last_a_acc, last_b_acc;

  always #5 clk = ~clk;

  mux_arbiter16 #(.WIDTH(WIDTH), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .y_valid(y_valid), .y_data(y_data), .y_src(y_src), .y_ready(y_ready),
    .sel(sel), .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  mux_arbiter16 #(.WIDTH(WIDTH), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready2),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready2),
    .y_valid(y_valid2), .y_data(y_data2), .y_src(y_src2), .y_ready(y_ready),
    .sel(sel2), .cnt_a(cnt2_a), .cnt_b(cnt2_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  // One clock cycle: drive inputs after the edge, check the handshake and
  // counters mid-cycle, then advance the model to what the next edge does.
  task automatic step(input logic av, input logic [15:0] ad,
                      input logic bv, input logic [15:0] bd, input logic yr);
    bit    any, g, load, ae, be;
    word_t w;
    @(posedge clk);
    #1;
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd; y_ready = yr;
    @(negedge clk);
    check("y_valid", y_valid, full_m);
    check("cnt_a", cnt_a, sat(cnt_am, 255));
    check("cnt_b", cnt_b, sat(cnt_bm, 255));
    check("cnt2_a", cnt2_a, sat(cnt_am, 3));
    check("cnt2_b", cnt2_b, sat(cnt_bm, 3));
    any = av || bv;
    g = (av && bv) ? prio_m : bv;
    check("sel", sel, any ? g : sel_m);
    load = !full_m || yr;
    ae = load && av && !g;
    be = load && bv && g;
    check("a_ready", a_ready, ae);
    check("b_ready", b_ready, be);
    last_a_acc = ae;
    last_b_acc = be;
    if (ae || be) begin
      w.src = g;
      w.data = g ? bd : ad;
      exp_q.push_back(w);
      if (g) cnt_bm++;
      else cnt_am++;
      prio_m = !g;
      full_m = 1'b1;
    end else if (yr) begin
      full_m = 1'b0;
    end
    if (any) sel_m = g;
  endtask

  task automatic clear_model();
    full_m = 0; prio_m = 0; sel_m = 0;
    cnt_am = 0; cnt_bm = 0;
    last_a_acc = 0; last_b_acc = 0;
    exp_q.delete();
  endtask

  task automatic check_reset_outputs();
    check("rst_y_valid", y_valid, 0);
    check("rst_y_data", y_data, 0);
    check("rst_y_src", y_src, 0);
    check("rst_sel", sel, 0);
    check("rst_cnt_a", cnt_a, 0);
    check("rst_cnt_b", cnt_b, 0);
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1;
    a_valid = 0; b_valid = 0; y_ready = 0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    clear_model();
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: a visible word must match the oldest expected one;
  // it is retired when the consumer takes it.
  always @(negedge clk) begin
    if (rst_n && y_valid) begin
      check("word_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        check("y_data", y_data, exp_q[0].data);
        check("y_src", y_src, exp_q[0].src);
        if (y_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic applyStimulus();
    logic        av, bv, yr;
    logic [15:0] ad, bd;
    av = 0; bv = 0; ad = '0; bd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!(av && !last_a_acc)) begin
        av = ($urandom_range(0, 2) != 0);
        ad = 16'($urandom());
      end
      if (!(bv && !last_b_acc)) begin
        bv = ($urandom_range(0, 2) != 0);
        bd = 16'($urandom());
      end
      yr = ($urandom_range(0, 3) != 0);
      step(av, ad, bv, bd, yr);
    end
  endtask

  initial begin
    clear_model();
    #12;
    check_reset_outputs();
    reset_dut();

    // Single A word.
    step(1, 16'h1234, 0, 16'h0, 1);
    step(0, 16'h0, 0, 16'h0, 1);
    step(0, 16'h0, 0, 16'h0, 1);
    check("single_cnt_a", cnt_a, 1);

    // Both valid: alternation from prio = A.
    reset_dut();
    for (int i = 0; i < 4; i++) step(1, 16'hAAAA, 1, 16'h5555, 1);
    step(0, 16'h0, 0, 16'h0, 1);
    step(0, 16'h0, 0, 16'h0, 1);
    check("alt_cnt_a", cnt_a, 2);
    check("alt_cnt_b", cnt_b, 2);

    // Backpressure with B waiting, then simultaneous drain and load.
    step(1, 16'h0F0F, 0, 16'h0, 1);
    for (int i = 0; i < 3; i++) step(0, 16'h0, 1, 16'hB0B0, 0);
    step(0, 16'h0, 1, 16'hB0B0, 1);
    step(0, 16'h0, 0, 16'h0, 1);
    step(0, 16'h0, 0, 16'h0, 1);

    // Asynchronous reset while holding a word.
    step(1, 16'h7777, 0, 16'h0, 0);
    step(0, 16'h0, 0, 16'h0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_y_valid", y_valid, 0);
    check("async_cnt_a", cnt_a, 0);
    @(negedge clk);
    clear_model();
    rst_n = 1'b1;
    step(1, 16'hC001, 1, 16'hC002, 1);
    step(0, 16'h0, 0, 16'h0, 1);
    step(0, 16'h0, 0, 16'h0, 1);

    // Saturation of the narrow counter.
    reset_dut();
    for (int i = 0; i < 5; i++) step(1, 16'(i + 1), 0, 16'h0, 1);
    step(0, 16'h0, 0, 16'h0, 1);
    step(0, 16'h0, 0, 16'h0, 1);
    check("sat_cnt2_a", cnt2_a, 3);
    check("sat_cnt_a", cnt_a, 5);

    // Random traffic.
    reset_dut();
    applyStimulus();
    for (int i = 0; i < 3; i++) step(0, 16'h0, 0, 16'h0, 1);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
